// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures instruction memory data into the IF/ID register.
// Optional valid-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hE,
  parameter logic [15:0]         NOP_INSTR   = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [15:0]         instr_data,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [15:0]         ir_out,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir_q;
  logic [PC_WIDTH-1:0] irPc_q;
  logic                irValid_q;
  logic                halted_q;
  logic                isHalt;

  assign isHalt = (instr_data[15:12] == HALT_OPCODE);

  // Branch wins over stall; a halt instruction is captured but the PC stays on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      irPc_q    <= '0;
      irValid_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_q      <= {branch_target[PC_WIDTH-1:1], 1'b0};
            ir_q      <= NOP_INSTR;
            irPc_q    <= '0;
            irValid_q <= 1'b0;
          end else if (!stall) begin
            ir_q      <= instr_data;
            irPc_q    <= pc_q;
            irValid_q <= 1'b1;
            if (isHalt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_WIDTH'(2);
            end
          end
        end
        HALT: begin
          irValid_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign ir_out   = ir_q;
  assign ir_pc    = irPc_q;
  assign ir_valid = irValid_q;
  assign halted   = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        loadValid;

  assign loadValid = (state_q == RUN) && !branch_taken && !stall;

  // Counts edges that load a real instruction, saturating at all-ones.
  always_comb begin
    count_d = count_q;
    if (loadValid && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized stall/branch traffic.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr_data;
  logic [15:0] pc_out;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:32767];

  int checks;
  int failures;

  // Reference view of the fetch stage
  logic [15:0] mPc;
  logic [15:0] mIr;
  logic [15:0] mIrPc;
  logic        mValid;
  logic        mHalted;
  int          mCount;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_data   (instr_data),
    .pc_out       (pc_out),
    .ir_out       (ir_out),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  assign instr_data = mem[pc_out[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPc     = 16'h0000;
    mIr     = 16'h0000;
    mIrPc   = 16'h0000;
    mValid  = 1'b0;
    mHalted = 1'b0;
    mCount  = 0;
  endtask

  task automatic modelEdge(input logic st, input logic br, input logic [15:0] bt);
    logic [15:0] word;
    if (mHalted) begin
      mValid = 1'b0;
    end else if (br) begin
      mPc    = bt & 16'hFFFE;
      mIr    = 16'h0000;
      mIrPc  = 16'h0000;
      mValid = 1'b0;
    end else if (!st) begin
      word   = mem[mPc / 2];
      mIr    = word;
      mIrPc  = mPc;
      mValid = 1'b1;
      if (mCount < 65535) mCount = mCount + 1;
      if (word[15:12] == 4'hE) mHalted = 1'b1;
      else mPc = 16'((32'(mPc) + 2) % 65536);
    end
  endtask

  function automatic logic [15:0] expectedCount();
`ifdef FETCH_PERF_CNT_EN
    return 16'(mCount);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic checkAll(input string phase);
    checkOutput({phase, ".pc"}, 32'(pc_out), 32'(mPc));
    checkOutput({phase, ".ir"}, 32'(ir_out), 32'(mIr));
    checkOutput({phase, ".irpc"}, 32'(ir_pc), 32'(mIrPc));
    checkOutput({phase, ".valid"}, 32'(ir_valid), 32'(mValid));
    checkOutput({phase, ".halted"}, 32'(halted), 32'(mHalted));
    checkOutput({phase, ".count"}, 32'(fetch_count), 32'(expectedCount()));
  endtask

  // Drives one cycle of inputs, advances the model and checks just after the edge
  task automatic applyStimulus(input string phase, input logic st, input logic br, input logic [15:0] bt);
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    modelEdge(st, br, bt);
    @(posedge clk);
    #1;
    checkAll(phase);
  endtask

  // Asynchronous reset pulse away from the clock edge
  task automatic applyReset(input string phase);
    reset = 1'b0;
    #2;
    modelReset();
    checkAll(phase);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;

    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      if (v[15:12] == 4'hE) v[15:12] = 4'h1;
      mem[i] = v;
    end
    mem[0]    = 16'h0120;
    mem[1]    = 16'h0121;
    mem[4]    = 16'h0564;
    mem[16'h12] = 16'h0B10;
    mem[16'h19] = 16'hEFFF;

    modelReset();
    #3;
    checkAll("reset0");
    repeat (2) @(posedge clk);
    #1;
    checkAll("resetHeld");
    reset = 1'b1;

    applyStimulus("fetch1", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.ir0120", 32'(ir_out), 32'h0120);
    checkOutput("tp.pc0002", 32'(pc_out), 32'h0002);
    applyStimulus("fetch2", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.ir0121", 32'(ir_out), 32'h0121);
    applyStimulus("fetch3", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.pc0006", 32'(pc_out), 32'h0006);

    repeat (3) applyStimulus("stall", 1'b1, 1'b0, 16'h0);
    checkOutput("tp.stallPc", 32'(pc_out), 32'h0006);
    applyStimulus("resume1", 1'b0, 1'b0, 16'h0);
    applyStimulus("resume2", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.ir0564", 32'(ir_out), 32'h0564);
    checkOutput("tp.irpc0008", 32'(ir_pc), 32'h0008);

    applyStimulus("branchStall", 1'b1, 1'b1, 16'h0025);
    checkOutput("tp.brPc", 32'(pc_out), 32'h0024);
    checkOutput("tp.brBubble", 32'(ir_valid), 32'h0);
    applyStimulus("branchTarget", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.ir0B10", 32'(ir_out), 32'h0B10);

    repeat (7) applyStimulus("toHalt", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.haltIr", 32'(ir_out), 32'hEFFF);
    checkOutput("tp.haltFlag", 32'(halted), 32'h1);
    checkOutput("tp.haltPc", 32'(pc_out), 32'h0032);
    applyStimulus("haltIdle", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.haltValid", 32'(ir_valid), 32'h0);
    repeat (3) applyStimulus("haltBranch", 1'b0, 1'b1, 16'h0100);
    checkOutput("tp.haltPcKept", 32'(pc_out), 32'h0032);

    applyReset("haltReset");
    applyStimulus("wrapBranch", 1'b0, 1'b1, 16'hFFFF);
    applyStimulus("wrapFetch", 1'b0, 1'b0, 16'h0);
    checkOutput("tp.wrapPc", 32'(pc_out), 32'h0000);

    applyReset("perfReset");
    repeat (3) applyStimulus("perfFetch", 1'b0, 1'b0, 16'h0);
    applyStimulus("perfBranch", 1'b0, 1'b1, 16'h0010);
    repeat (2) applyStimulus("perfStall", 1'b1, 1'b0, 16'h0);
    repeat (2) applyStimulus("perfFetch", 1'b0, 1'b0, 16'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("tp.count5", 32'(fetch_count), 32'd5);
`else
    checkOutput("tp.count0", 32'(fetch_count), 32'd0);
`endif
    #2;
    applyReset("perfMidReset");

    for (int i = 0; i < 400; i++) begin
      logic st;
      logic br;
      logic [15:0] bt;
      if (mHalted && ($urandom_range(0, 7) == 0)) applyReset("rndReset");
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      applyStimulus("random", st, br, bt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
